regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file with participation-masked writes, participation-aware write-to-read bypass and a self-clearing sweep engine. Successor to the fixed 32x64 two-read-port file. Sits between decode (read operands) and write-back (masked writes) in the pipeline. The array itself is not reset; instead a sweep FSM zeroes it after reset or on request.

## Interface
- DATA_W, 64: register width; must be a multiple of 16.
- DEPTH, 32: number of registers; power of two, at least 4.
- NRD, 2: number of read ports, 1..4.
- AW, $clog2(DEPTH): address width (derived; do not override).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*DATA_W  packed read data, combinational.
- wr_en  in  1  write-back enable.
- wr_addr  in  AW  write address.
- wr_data  in  DATA_W  write data.
- wr_ppp  in  3  participation code.
- clr_req  in  1  single-cycle request to re-clear the whole array.
- ready  out  1  high when the file accepts writes and returns stored data.
- wr_drop  out  1  one-cycle pulse when a write is discarded because the sweep is active.
- wr_err  out  1  sticky flag for an illegal wr_ppp.

## Operation
- Participation mask, in units of bytes, from wr_ppp:
  - 000: all bytes.
  - 001: upper half.
  - 010: lower half.
  - 011: odd bytes (byte 1, 3, 5, ...; bits [15:8], [31:24], ...).
  - 100: even bytes (byte 0, 2, ...).
  - 101, 110, 111: illegal. No bytes are written; wr_err is set.
- Register 0 always reads zero. Writes to address 0 are ignored: no error and no drop.
- FSM states:
  - CLEAR: ready=0. Each cycle writes zero to entry sweep_cnt and increments sweep_cnt. When sweep_cnt==DEPTH-1 is written, go to READY.
  - READY: ready=1. clr_req moves the FSM to CLEAR with sweep_cnt=0 on the next edge.
- In CLEAR, all rd_data are forced to zero.
- In CLEAR, wr_en with wr_addr!=0 is discarded and pulses wr_drop in the same cycle (combinational). clr_req in CLEAR is ignored.
- clr_req and wr_en in the same READY cycle: the write commits. The sweep starts on the next cycle and later zeroes that entry.
- wr_err:
  - Sets on the edge after an illegal wr_ppp with wr_en=1 and ready=1.
  - Clears on reset, or on an accepted clr_req (the same edge the FSM enters CLEAR).
  - If set and clear coincide, clear wins.
- Bypass (when compiled in): if ready, wr_en, wr_addr!=0, the ppp is legal and rd_addr==wr_addr, then rd_data = (wr_data & mask) | (stored & ~mask). The merge is per byte, per read port independently.

## Timing
- Reads: zero latency, combinational from rd_addr, the array and the bypass inputs.
- Writes: visible in the array one edge after wr_en.
- Reset assertion immediately, asynchronously forces:
  - state=CLEAR, sweep_cnt=0, ready=0, wr_err=0.
  - wr_drop follows combinationally.
  - Array contents are undefined until the sweep completes.
- After reset deasserts, ready rises after exactly DEPTH rising edges.
- A clr_req accepted at edge N gives ready=0 from N to N+DEPTH, and ready=1 after edge N+DEPTH.
- Reset asserted mid-sweep restarts the sweep at entry 0.
- sweep_cnt wraps to 0 on leaving CLEAR. It never exceeds DEPTH-1.

## Configuration
- REGFILE_FWD_EN defined: same-cycle masked bypass as described under Operation.
- REGFILE_FWD_EN undefined: reads always return the stored array value. A write becomes visible on the cycle after its edge. There is no combinational path from wr_* to rd_data.

## Structure
- regfile_pkg holds:
  - The PPP_ALL, PPP_HI, PPP_LO, PPP_ODD and PPP_EVEN code constants.
  - The state enum {CLEAR, READY}.
  - A function ppp_legal(ppp).
- Sub-module regfile_ppp_mask (parameter DATA_W):
  - Input: wr_ppp.
  - Outputs: byte mask of DATA_W/8 bits, and an illegal flag.
  - Shared by the write path and the bypass merge.

## Test plan
- Reset release, DATA_W=64, DEPTH=32: ready=0 for 32 edges, then ready=1. All reads return 0 during and after the sweep.
- Write 0x1111_2222_3333_4444 to r5 with ppp=000, then write 0xAAAA_BBBB_CCCC_DDDD with ppp=011. Next-cycle read of r5 returns 0xAA11_BB22_CC33_DD44.
- REGFILE_FWD_EN defined: r7 holds 0x0, and a write of 0xFFFF_FFFF_FFFF_FFFF with ppp=010 is active. A same-cycle read of r7 returns 0x0000_0000_FFFF_FFFF. With the macro undefined, the same-cycle read returns 0x0.
- wr_ppp=110 to r3 in READY: r3 is unchanged and wr_err=1 after the edge. A following clr_req clears wr_err and drops ready for 32 cycles.
- Write during the sweep: wr_drop=1 that cycle, and the target reads 0 once ready is high.
- Reset asserted at sweep_cnt=17: after release, ready stays low for a full 32 edges. Also check NRD=4, DEPTH=16 and DATA_W=128, with all four ports reading distinct written values.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: participation codes, FSM states, legality helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam logic [2:0] PPP_ALL  = 3'b000;
    localparam logic [2:0] PPP_HI   = 3'b001;
    localparam logic [2:0] PPP_LO   = 3'b010;
    localparam logic [2:0] PPP_ODD  = 3'b011;
    localparam logic [2:0] PPP_EVEN = 3'b100;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Codes above PPP_EVEN are reserved and write nothing.
    function automatic logic ppp_legal(input logic [2:0] ppp);
        return (ppp <= PPP_EVEN);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Operand-read and write-back bundle of the register file.
// Latency: n/a (wires only).
// Backpressure: ready low means writes are dropped and reads return zero.
interface regfile_mp_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int NRD    = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [2:0]            wr_ppp;
    logic                  clr_req;
    logic                  ready;
    logic                  wr_drop;
    logic                  wr_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_ppp, clr_req,
        input  rd_data, ready, wr_drop, wr_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_ppp, clr_req,
        output rd_data, ready, wr_drop, wr_err
    );

endinterface

// File: rtl/regfile_ppp_mask.sv
// Decodes a participation code into a per-byte write mask plus an illegal-code flag.
// Latency: combinational.
// Backpressure: none; illegal codes yield an all-zero mask.
module regfile_ppp_mask
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]          wr_ppp,
    output logic [DATA_W/8-1:0] byte_mask,
    output logic                illegal
);
    localparam int NB = DATA_W / 8;

    // One mask bit per byte lane; byte 0 is the least significant lane.
    always_comb begin
        byte_mask = '0;
        illegal   = !ppp_legal(wr_ppp);
        for (int b = 0; b < NB; b++) begin
            case (wr_ppp)
                PPP_ALL:  byte_mask[b] = 1'b1;
                PPP_HI:   byte_mask[b] = (b >= NB / 2);
                PPP_LO:   byte_mask[b] = (b < NB / 2);
                PPP_ODD:  byte_mask[b] = ((b % 2) == 1);
                PPP_EVEN: byte_mask[b] = ((b % 2) == 0);
                default:  byte_mask[b] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-masked writes and a sweep FSM that zeroes the array. Optional bypass: REGFILE_FWD_EN.
// Latency: reads combinational; writes visible one edge later (same cycle through the bypass when REGFILE_FWD_EN).
// Backpressure: while sweeping, ready=0, reads return zero and writes are dropped with a wr_drop pulse.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int NRD    = 2
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     sweep_cnt;
    logic              is_ready;
    logic              sweeping;
    logic              addr_nz;
    logic              ppp_bad;
    logic              wr_commit;
    logic              wr_bad;
    logic              clr_take;
    logic              err_q;
    logic [NB-1:0]     byte_mask;
    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word [NRD];

    regfile_ppp_mask #(.DATA_W(DATA_W)) u_mask (
        .wr_ppp    (bus.wr_ppp),
        .byte_mask (byte_mask),
        .illegal   (ppp_bad)
    );

    // Expand the byte mask to bit granularity for the write merge and bypass.
    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < NB; b++) begin
            bit_mask[b*8 +: 8] = {8{byte_mask[b]}};
        end
    end

    assign addr_nz   = (bus.wr_addr != '0);
    assign wr_commit = is_ready && bus.wr_en && addr_nz && !ppp_bad;
    assign wr_bad    = is_ready && bus.wr_en && addr_nz && ppp_bad;
    assign clr_take  = is_ready && bus.clr_req;

    // FSM state register; reset always restarts the sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: leave CLEAR once the last entry is zeroed.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (sweep_cnt == AW'(DEPTH - 1)) state_nxt = READY;
            READY:   if (bus.clr_req) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // FSM outputs; wr_drop is combinational so it tracks reset immediately.
    always_comb begin
        is_ready    = (state == READY);
        sweeping    = (state == CLEAR);
        bus.ready   = is_ready;
        bus.wr_drop = sweeping && bus.wr_en && addr_nz;
    end

    // Sweep pointer: walks the array in CLEAR and wraps to 0 on the final entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_cnt <= '0;
        end else if (sweeping) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end else begin
            sweep_cnt <= '0;
        end
    end

    // Sticky illegal-code flag; an accepted clear request wins over a new error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (clr_take) begin
            err_q <= 1'b0;
        end else if (wr_bad) begin
            err_q <= 1'b1;
        end
    end

    assign bus.wr_err = err_q;

    // Array storage is not reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (sweeping) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_commit) begin
            mem[bus.wr_addr] <= (bus.wr_data & bit_mask) | (mem[bus.wr_addr] & ~bit_mask);
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] merged;

        assign ra     = bus.rd_addr[k*AW +: AW];
        assign stored = (ra == '0) ? '0 : mem[ra];
`ifdef REGFILE_FWD_EN
        assign merged = (wr_commit && (ra == bus.wr_addr)) ?
                        ((bus.wr_data & bit_mask) | (stored & ~bit_mask)) : stored;
`else
        assign merged = stored;
`endif
        assign rd_word[k] = is_ready ? merged : '0;
    end

    // Pack the per-port read words onto the bus.
    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            bus.rd_data[k*DATA_W +: DATA_W] = rd_word[k];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 64x32x2 instance checked against an array model, plus a 128x16x4 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_mp;

    localparam int W1 = 64;
    localparam int D1 = 32;
    localparam int N1 = 2;
    localparam int A1 = 5;
    localparam int W2 = 128;
    localparam int D2 = 16;
    localparam int N2 = 4;
    localparam int A2 = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(W1), .DEPTH(D1), .NRD(N1)) b1 ();
    regfile_mp_if #(.DATA_W(W2), .DEPTH(D2), .NRD(N2)) b2 ();

    regfile_mp #(.DATA_W(W1), .DEPTH(D1), .NRD(N1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    regfile_mp #(.DATA_W(W2), .DEPTH(D2), .NRD(N2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the 64-bit instance: contents, cycles of sweep left, sticky error.
    logic [W1-1:0] mdl [D1];
    int            left;
    bit            err;
    bit            in_rst;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W1-1:0] mask64(input logic [2:0] p);
        logic [W1-1:0] m;
        bit on;
        m = '0;
        for (int i = 0; i < W1 / 8; i++) begin
            case (p)
                3'd0:    on = 1'b1;
                3'd1:    on = (i >= 4);
                3'd2:    on = (i < 4);
                3'd3:    on = (i % 2 == 1);
                3'd4:    on = (i % 2 == 0);
                default: on = 1'b0;
            endcase
            if (on) m[i*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    function automatic logic [W1-1:0] exp_rd(input logic [A1-1:0] a);
        logic [W1-1:0] v;
        if (in_rst || left > 0) return '0;
        v = (a == 0) ? '0 : mdl[a];
`ifdef REGFILE_FWD_EN
        if (b1.wr_en && a != 0 && a == b1.wr_addr && b1.wr_ppp <= 3'd4)
            v = (b1.wr_data & mask64(b1.wr_ppp)) | (v & ~mask64(b1.wr_ppp));
`endif
        return v;
    endfunction

    task automatic compare_all();
        bit busy;
        busy = in_rst || left > 0;
        for (int k = 0; k < N1; k++) begin
            chk($sformatf("rd%0d_a%0d", k, b1.rd_addr[k*A1 +: A1]),
                b1.rd_data[k*W1 +: W1], exp_rd(b1.rd_addr[k*A1 +: A1]));
        end
        chk("ready", b1.ready, !busy);
        chk("wr_drop", b1.wr_drop, busy && b1.wr_en && b1.wr_addr != 0);
        chk("wr_err", b1.wr_err, err);
    endtask

    task automatic model_edge();
        if (in_rst) return;
        if (left > 0) begin
            left--;
            return;
        end
        if (b1.wr_en && b1.wr_addr != 0) begin
            if (b1.wr_ppp <= 3'd4)
                mdl[b1.wr_addr] = (b1.wr_data & mask64(b1.wr_ppp)) | (mdl[b1.wr_addr] & ~mask64(b1.wr_ppp));
            else
                err = 1'b1;
        end
        if (b1.clr_req) begin
            err  = 1'b0;
            left = D1;
            for (int i = 0; i < D1; i++) mdl[i] = '0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle1();
        b1.wr_en   = 1'b0;
        b1.clr_req = 1'b0;
        b1.wr_ppp  = 3'd0;
    endtask

    task automatic wr1(input logic [A1-1:0] a, input logic [W1-1:0] d, input logic [2:0] p);
        b1.wr_en   = 1'b1;
        b1.wr_addr = a;
        b1.wr_data = d;
        b1.wr_ppp  = p;
    endtask

    task automatic wr2(input logic [A2-1:0] a, input logic [W2-1:0] d, input logic [2:0] p);
        b2.wr_en   = 1'b1;
        b2.wr_addr = a;
        b2.wr_data = d;
        b2.wr_ppp  = p;
        step();
        b2.wr_en   = 1'b0;
    endtask

    task automatic release_reset(output int c1, output int c2);
        reset  = 1'b1;
        in_rst = 1'b0;
        left   = D1;
        err    = 1'b0;
        for (int i = 0; i < D1; i++) mdl[i] = '0;
        c1 = 0;
        c2 = 0;
        for (int i = 1; i <= 40; i++) begin
            b1.rd_addr = N1*A1'($urandom);
            step();
            if (b1.ready && c1 == 0) c1 = i;
            if (b2.ready && c2 == 0) c2 = i;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int c1;
        int c2;
        logic [W2-1:0] v2 [4];

        in_rst = 1'b1;
        err    = 1'b0;
        left   = 0;
        for (int i = 0; i < D1; i++) mdl[i] = '0;
        b1.rd_addr = '0; b1.wr_addr = '0; b1.wr_data = '0;
        idle1();
        b2.rd_addr = '0; b2.wr_addr = '0; b2.wr_data = '0;
        b2.wr_en = 1'b0; b2.wr_ppp = 3'd0; b2.clr_req = 1'b0;

        // Reset state
        #2;
        chk("rst_ready1", b1.ready, 1'b0);
        chk("rst_err1", b1.wr_err, 1'b0);
        chk("rst_ready2", b2.ready, 1'b0);
        wr1(5'd3, 64'h1, 3'd0);
        #1;
        chk("rst_drop", b1.wr_drop, 1'b1);
        idle1();
        repeat (3) step();

        // Sweep after release: 32 edges for DEPTH=32, 16 for DEPTH=16
        release_reset(c1, c2);
        chk("sweep_len1", c1, 32);
        chk("sweep_len2", c2, 16);

        // Masked odd-byte write over a full write
        b1.rd_addr = {5'd0, 5'd5};
        wr1(5'd5, 64'h1111_2222_3333_4444, 3'd0);
        step();
        wr1(5'd5, 64'hAAAA_BBBB_CCCC_DDDD, 3'd3);
        step();
        idle1();
        #1;
        chk("r5_odd_merge", b1.rd_data[63:0], 64'hAA11_BB22_CC33_DD44);

        // Same-cycle read of a lower-half write
        b1.rd_addr = {5'd7, 5'd5};
        wr1(5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2);
        #1;
`ifdef REGFILE_FWD_EN
        chk("r7_bypass", b1.rd_data[127:64], 64'h0000_0000_FFFF_FFFF);
`else
        chk("r7_no_bypass", b1.rd_data[127:64], 64'h0);
`endif
        step();
        idle1();
        #1;
        chk("r7_stored", b1.rd_data[127:64], 64'h0000_0000_FFFF_FFFF);

        // Illegal code leaves the entry alone and sets the sticky error
        b1.rd_addr = {5'd9, 5'd3};
        wr1(5'd3, 64'h3333_3333_3333_3333, 3'd0);
        step();
        wr1(5'd3, 64'hDEAD_BEEF_DEAD_BEEF, 3'd6);
        step();
        idle1();
        #1;
        chk("r3_unchanged", b1.rd_data[63:0], 64'h3333_3333_3333_3333);
        chk("err_set", b1.wr_err, 1'b1);
        b1.clr_req = 1'b1;
        step();
        b1.clr_req = 1'b0;
        chk("err_cleared", b1.wr_err, 1'b0);
        chk("clr_ready_low", b1.ready, 1'b0);
        c1 = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                wr1(5'd9, 64'h5555_5555_5555_5555, 3'd0);
                #1;
                chk("sweep_drop", b1.wr_drop, 1'b1);
            end
            step();
            idle1();
            if (b1.ready && c1 == 0) c1 = i;
        end
        chk("clr_len", c1, 32);
        #1;
        chk("r9_dropped", b1.rd_data[127:64], 64'h0);

        // Reset in the middle of a sweep restarts it from entry 0
        b1.clr_req = 1'b1;
        step();
        b1.clr_req = 1'b0;
        repeat (17) step();
        reset  = 1'b0;
        in_rst = 1'b1;
        err    = 1'b0;
        #1;
        chk("midrst_ready", b1.ready, 1'b0);
        repeat (2) step();
        release_reset(c1, c2);
        chk("midrst_len1", c1, 32);
        chk("midrst_len2", c2, 16);

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            b1.wr_en   = ($urandom_range(0, 9) < 6);
            b1.wr_addr = ($urandom_range(0, 1) == 1) ? A1'($urandom_range(0, 3)) : A1'($urandom);
            b1.wr_data = {$urandom, $urandom};
            b1.wr_ppp  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            b1.clr_req = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < N1; k++) begin
                b1.rd_addr[k*A1 +: A1] = ($urandom_range(0, 2) == 0) ? b1.wr_addr : A1'($urandom_range(0, 3));
            end
            step();
        end
        idle1();
        repeat (40) step();

        // Wide instance: four ports reading four distinct registers
        v2[0] = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        v2[1] = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
        v2[2] = 128'h1357_9BDF_2468_ACE0_0F1E_2D3C_4B5A_6978;
        v2[3] = 128'hCAFE_F00D_BAAD_C0DE_1234_5678_9ABC_DEF0;
        wr2(4'd1,  v2[0], 3'd0);
        wr2(4'd6,  v2[1], 3'd0);
        wr2(4'd11, v2[2], 3'd0);
        wr2(4'd15, v2[3], 3'd0);
        wr2(4'd6, {128{1'b1}}, 3'd1);
        b2.rd_addr = {4'd15, 4'd11, 4'd6, 4'd1};
        #1;
        chk("w_port0", b2.rd_data[0*W2 +: W2], v2[0]);
        chk("w_port1", b2.rd_data[1*W2 +: W2], {64'hFFFF_FFFF_FFFF_FFFF, v2[1][63:0]});
        chk("w_port2", b2.rd_data[2*W2 +: W2], v2[2]);
        chk("w_port3", b2.rd_data[3*W2 +: W2], v2[3]);
        b2.rd_addr = {4'd1, 4'd15, 4'd11, 4'd0};
        #1;
        chk("w_r0", b2.rd_data[0*W2 +: W2], 128'h0);
        chk("w_port3b", b2.rd_data[3*W2 +: W2], v2[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
